// File: rtl/memwb_pkg.sv
// memwb_pkg: state encoding and entry-record layout helpers for memwb_pipe.
package memwb_pkg;

  // Skid-buffer occupancy states; the encoding doubles as the occupancy count.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_e;

  // Control bits carried in every entry: mem_r and reg_w.
  localparam int CTRL_W = 2;

  // Width of the CP0 portion of an entry: destination address plus write enable.
  function automatic int cp0_field_w(input int addr_w);
    return addr_w + 1;
  endfunction

  // Total flattened entry width for the given datapath widths.
  function automatic int entry_w(input int data_w, input int addr_w,
                                 input int be_w, input bit cp0_en);
    return CTRL_W + be_w + addr_w + (2 * data_w) +
           (cp0_en ? cp0_field_w(addr_w) : 0);
  endfunction

endpackage

// File: rtl/memwb_slot.sv
// memwb_slot: one load-enabled storage slot of the MEM/WB skid buffer.
// Contents are cleared by reset and otherwise hold until loaded.
module memwb_slot #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] q_r;

  // Slot register: cleared on reset, captured on load, held otherwise.
  always_ff @(negedge clk) begin
    if (reset) begin
      q_r <= {W{1'b0}};
    end else if (load) begin
      q_r <= d;
    end else begin
      q_r <= q_r;
    end
  end

  assign q = q_r;

endmodule

// File: rtl/memwb_pipe.sv
// memwb_pipe: 2-entry skid buffer between the MEM and WB stages.
// Slot 0 is always the head; slot 1 holds the skid entry while WB stalls.
// Optional feature macro: MEMWB_CP0_EN (keeps CP0 address/write-enable storage).
module memwb_pipe
  import memwb_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int BE_W   = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_mem_r,
  input  logic              in_reg_w,
  input  logic [BE_W-1:0]   in_byte_en,
  input  logic [ADDR_W-1:0] in_rd_addr,
  input  logic [DATA_W-1:0] in_mem_data,
  input  logic [DATA_W-1:0] in_ex_data,
  input  logic [ADDR_W-1:0] in_cp0_addr,
  input  logic              in_cp0_w_en,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_mem_r,
  output logic              out_reg_w,
  output logic [BE_W-1:0]   out_byte_en,
  output logic [ADDR_W-1:0] out_rd_addr,
  output logic [DATA_W-1:0] out_mem_data,
  output logic [DATA_W-1:0] out_ex_data,
  output logic [ADDR_W-1:0] out_cp0_addr,
  output logic              out_cp0_w_en,
  output logic [DATA_W-1:0] out_wb_data,
  output logic [1:0]        occupancy
);

`ifdef MEMWB_CP0_EN
  localparam bit CP0_EN = 1'b1;
`else
  localparam bit CP0_EN = 1'b0;
`endif

  localparam int ENT_W = entry_w(DATA_W, ADDR_W, BE_W, CP0_EN);

  state_e             state_r;
  state_e             state_nxt_s;
  logic               push_s;
  logic               pop_s;
  logic               load0_s;
  logic               load1_s;
  logic               sel_skid_s;
  logic [ENT_W-1:0]   in_ent_s;
  logic [ENT_W-1:0]   slot0_d_s;
  logic [ENT_W-1:0]   slot0_q_s;
  logic [ENT_W-1:0]   slot1_q_s;

  logic               head_mem_r_s;
  logic               head_reg_w_s;
  logic [BE_W-1:0]    head_byte_en_s;
  logic [ADDR_W-1:0]  head_rd_addr_s;
  logic [DATA_W-1:0]  head_mem_data_s;
  logic [DATA_W-1:0]  head_ex_data_s;
  logic [ADDR_W-1:0]  head_cp0_addr_s;
  logic               head_cp0_w_en_s;

  // Handshake status comes from the state register only, so in_ready never
  // depends combinationally on out_ready.
  assign in_ready  = (state_r != ST_TWO);
  assign out_valid = (state_r == ST_ONE) || (state_r == ST_TWO);
  assign occupancy = state_r;
  assign push_s    = in_valid && in_ready;
  assign pop_s     = out_valid && out_ready;

`ifdef MEMWB_CP0_EN
  assign in_ent_s = {in_mem_r, in_reg_w, in_byte_en, in_rd_addr,
                     in_mem_data, in_ex_data, in_cp0_addr, in_cp0_w_en};
  assign {head_mem_r_s, head_reg_w_s, head_byte_en_s, head_rd_addr_s,
          head_mem_data_s, head_ex_data_s, head_cp0_addr_s,
          head_cp0_w_en_s} = slot0_q_s;
`else
  // CP0 inputs are not stored; fold them into a sink so they stay visible.
  logic unused_cp0_s;
  assign unused_cp0_s = ^{in_cp0_addr, in_cp0_w_en};
  assign in_ent_s = {in_mem_r, in_reg_w, in_byte_en, in_rd_addr,
                     in_mem_data, in_ex_data};
  assign {head_mem_r_s, head_reg_w_s, head_byte_en_s, head_rd_addr_s,
          head_mem_data_s, head_ex_data_s} = slot0_q_s;
  assign head_cp0_addr_s = {ADDR_W{1'b0}};
  assign head_cp0_w_en_s = 1'b0;
`endif

  // State register; reset wins over everything, including a stalled TWO.
  always_ff @(negedge clk) begin
    if (reset) begin
      state_r <= ST_EMPTY;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state and slot-load control; flush overrides push and pop.
  always_comb begin
    state_nxt_s = state_r;
    load0_s     = 1'b0;
    load1_s     = 1'b0;
    sel_skid_s  = 1'b0;
    if (flush) begin
      state_nxt_s = ST_EMPTY;
    end else begin
      case (state_r)
        ST_EMPTY: begin
          if (push_s) begin
            state_nxt_s = ST_ONE;
            load0_s     = 1'b1;
          end else begin
            state_nxt_s = ST_EMPTY;
          end
        end
        ST_ONE: begin
          if (push_s && pop_s) begin
            state_nxt_s = ST_ONE;
            load0_s     = 1'b1;
          end else if (push_s) begin
            state_nxt_s = ST_TWO;
            load1_s     = 1'b1;
          end else if (pop_s) begin
            state_nxt_s = ST_EMPTY;
          end else begin
            state_nxt_s = ST_ONE;
          end
        end
        ST_TWO: begin
          if (pop_s) begin
            state_nxt_s = ST_ONE;
            load0_s     = 1'b1;
            sel_skid_s  = 1'b1;
          end else begin
            state_nxt_s = ST_TWO;
          end
        end
        default: begin
          state_nxt_s = ST_EMPTY;
        end
      endcase
    end
  end

  // Head slot takes either the incoming entry or the promoted skid entry.
  assign slot0_d_s = sel_skid_s ? slot1_q_s : in_ent_s;

  memwb_slot #(.W(ENT_W)) u_slot0 (
    .clk   (clk),
    .reset (reset),
    .load  (load0_s),
    .d     (slot0_d_s),
    .q     (slot0_q_s)
  );

  memwb_slot #(.W(ENT_W)) u_slot1 (
    .clk   (clk),
    .reset (reset),
    .load  (load1_s),
    .d     (in_ent_s),
    .q     (slot1_q_s)
  );

  // Data fields pass straight from the head slot; write enables are gated
  // by out_valid so WB never writes from a stale slot.
  assign out_mem_r    = head_mem_r_s;
  assign out_rd_addr  = head_rd_addr_s;
  assign out_mem_data = head_mem_data_s;
  assign out_ex_data  = head_ex_data_s;
  assign out_cp0_addr = head_cp0_addr_s;
  assign out_reg_w    = out_valid & head_reg_w_s;
  assign out_cp0_w_en = out_valid & head_cp0_w_en_s;
  assign out_byte_en  = out_valid ? head_byte_en_s : {BE_W{1'b0}};
  assign out_wb_data  = head_mem_r_s ? head_mem_data_s : head_ex_data_s;

endmodule
